// File: rtl/x_stretch_if.sv
// Trigger/control/status bundle for the x_stretch pulse stretcher.
// The master drives the trigger and configuration; the slave returns the stretched pulse and status.
interface x_stretch_if #(
    parameter int MXCNT = 4
);
    logic             d;
    logic [MXCNT-1:0] len;
    logic [MXCNT-1:0] gap;
    logic             retrig;
    logic             drop_clr;
    logic             q;
    logic             busy;
    logic [7:0]       drop_cnt;

    modport master (
        output d, len, gap, retrig, drop_clr,
        input  q, busy, drop_cnt
    );

    modport slave (
        input  d, len, gap, retrig, drop_clr,
        output q, busy, drop_cnt
    );
endinterface

// File: rtl/x_stretch.sv
// Pulse stretcher: each accepted one-clock trigger becomes a registered pulse of max(len,1)
// clocks, followed by at least gap+1 low clocks. Define X_STRETCH_DROP_CNT_EN for the drop counter.
module x_stretch #(
    parameter int MXCNT = 4
) (
    input logic        clock,
    input logic        reset,
    x_stretch_if.slave bus
);
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StStretch = 2'd1,
        StGap     = 2'd2
    } sm_e;

    localparam logic [MXCNT-1:0] CntOne = MXCNT'(1);

    sm_e              sm_q;
    logic [MXCNT-1:0] cnt_q;
    logic [MXCNT-1:0] gcnt_q;
    logic             q_q;
    logic             busy_q;
    logic [MXCNT-1:0] len_m1;

    // len of 0 stretches like len of 1
    assign len_m1 = (bus.len == '0) ? '0 : (bus.len - CntOne);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sm_q   <= StIdle;
            cnt_q  <= '0;
            gcnt_q <= '0;
            q_q    <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            case (sm_q)
                StIdle: begin
                    if (bus.d) begin
                        q_q    <= 1'b1;
                        busy_q <= 1'b1;
                        cnt_q  <= len_m1;
                        sm_q   <= StStretch;
                    end
                end
                StStretch: begin
                    if (bus.retrig && bus.d) begin
                        cnt_q <= len_m1;
                    end else if (cnt_q == '0) begin
                        q_q <= 1'b0;
                        if (bus.gap == '0) begin
                            sm_q   <= StIdle;
                            busy_q <= 1'b0;
                        end else begin
                            gcnt_q <= bus.gap - CntOne;
                            sm_q   <= StGap;
                        end
                    end else begin
                        cnt_q <= cnt_q - CntOne;
                    end
                end
                StGap: begin
                    if (gcnt_q == '0) begin
                        sm_q   <= StIdle;
                        busy_q <= 1'b0;
                    end else begin
                        gcnt_q <= gcnt_q - CntOne;
                    end
                end
                default: begin
                    sm_q   <= StIdle;
                    q_q    <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.q    = q_q;
    assign bus.busy = busy_q;

`ifdef X_STRETCH_DROP_CNT_EN
    logic       dropped;
    logic [7:0] drop_q;

    // A trigger counts as dropped unless it loads (idle) or reloads (stretch with retrig)
    assign dropped = bus.d && !((sm_q == StIdle) || ((sm_q == StStretch) && bus.retrig));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_q <= 8'h00;
        end else if (bus.drop_clr) begin
            drop_q <= 8'h00;
        end else if (dropped && (drop_q != 8'hff)) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign bus.drop_cnt = drop_q;
`else
    logic unused_drop_clr;

    assign unused_drop_clr = bus.drop_clr;
    assign bus.drop_cnt    = 8'h00;
`endif
endmodule

// File: tb/tb_x_stretch.sv
// Self-checking bench for x_stretch: vector table, hand-written corner sequences and a
// randomized run against a remaining-time reference model.
module tb_x_stretch;
    localparam int MXCNT = 4;

    logic clock;
    logic reset;

    x_stretch_if #(.MXCNT(MXCNT)) bus ();

    x_stretch #(.MXCNT(MXCNT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: clocks of high output left, clocks of enforced low left, drop tally
    int m_hi   = 0;
    int m_lo   = 0;
    int m_drop = 0;

    typedef struct {
        logic       d;
        logic [3:0] len;
        logic [3:0] gap;
        logic       retrig;
        logic       q;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int exp_drop();
`ifdef X_STRETCH_DROP_CNT_EN
        return m_drop;
`else
        return 0;
`endif
    endfunction

    function automatic void model_step();
        int L;
        bit dropped;
        L       = (bus.len == 0) ? 1 : int'(bus.len);
        dropped = 1'b0;
        if (m_hi == 0 && m_lo == 0) begin
            if (bus.d) m_hi = L;
        end else if (m_hi > 0) begin
            if (bus.retrig && bus.d) begin
                m_hi = L;
            end else begin
                dropped = bus.d;
                m_hi--;
                if (m_hi == 0) m_lo = int'(bus.gap);
            end
        end else begin
            dropped = bus.d;
            m_lo--;
        end
        if (bus.drop_clr) m_drop = 0;
        else if (dropped && m_drop < 255) m_drop++;
    endfunction

    task automatic tick();
        if (!reset) model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".q"}, 32'(bus.q), 32'(m_hi > 0));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(m_hi > 0 || m_lo > 0));
        chk({tag, ".drop"}, 32'(bus.drop_cnt), 32'(exp_drop()));
    endtask

    task automatic add(input logic d, input logic [3:0] len, input logic [3:0] gap,
                       input logic retrig, input logic q, input logic busy);
        vec_t v;
        v.d = d; v.len = len; v.gap = gap; v.retrig = retrig; v.q = q; v.busy = busy;
        vecs.push_back(v);
    endtask

    initial begin
        // Single pulse: len 3, d at edge 10
        for (int i = 0; i < 10; i++) add(1'b0, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 4'd3, 4'd0, 1'b0, 1'b1, 1'b1);
        add(1'b0, 4'd3, 4'd0, 1'b0, 1'b1, 1'b1);
        add(1'b0, 4'd3, 4'd0, 1'b0, 1'b1, 1'b1);
        add(1'b0, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0);
        // Retrigger: len 4, d at relative edges 0 and 2 -> six high clocks
        add(1'b1, 4'd4, 4'd0, 1'b1, 1'b1, 1'b1);
        add(1'b0, 4'd4, 4'd0, 1'b1, 1'b1, 1'b1);
        add(1'b1, 4'd4, 4'd0, 1'b1, 1'b1, 1'b1);
        add(1'b0, 4'd4, 4'd0, 1'b1, 1'b1, 1'b1);
        add(1'b0, 4'd4, 4'd0, 1'b1, 1'b1, 1'b1);
        add(1'b0, 4'd4, 4'd0, 1'b1, 1'b1, 1'b1);
        add(1'b0, 4'd4, 4'd0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 4'd4, 4'd0, 1'b1, 1'b0, 1'b0);

        bus.d = 1'b0; bus.len = '0; bus.gap = '0; bus.retrig = 1'b0; bus.drop_clr = 1'b0;
        reset = 1'b1;
        #1;
        chk("reset.q", 32'(bus.q), 32'd0);
        chk("reset.busy", 32'(bus.busy), 32'd0);
        chk("reset.drop", 32'(bus.drop_cnt), 32'd0);
        tick();
        tick();
        #2 reset = 1'b0;
        @(posedge clock);
        #1;

        foreach (vecs[i]) begin
            bus.d = vecs[i].d; bus.len = vecs[i].len; bus.gap = vecs[i].gap;
            bus.retrig = vecs[i].retrig;
            tick();
            chk($sformatf("vec%0d.q", i), 32'(bus.q), 32'(vecs[i].q));
            chk($sformatf("vec%0d.busy", i), 32'(bus.busy), 32'(vecs[i].busy));
            chk($sformatf("vec%0d.drop", i), 32'(bus.drop_cnt), 32'd0);
        end

        // No retrigger, gap 3, d held 12 clocks: 2 high / 4 low
        bus.len = 4'd2; bus.gap = 4'd3; bus.retrig = 1'b0; bus.d = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("gap.q%0d", i), 32'(bus.q), 32'((i % 6) < 2));
            check_model("gap");
        end
        bus.d = 1'b0;
        tick();
        check_model("gap.end");
        for (int i = 0; i < 6; i++) tick();

        // len 0, back-to-back: alternating output
        bus.drop_clr = 1'b1;
        tick();
        bus.drop_clr = 1'b0;
        chk("clr.drop", 32'(bus.drop_cnt), 32'd0);
        bus.len = 4'd0; bus.gap = 4'd0; bus.d = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("alt.q%0d", i), 32'(bus.q), 32'((i % 2) == 0));
`ifdef X_STRETCH_DROP_CNT_EN
            chk($sformatf("alt.drop%0d", i), 32'(bus.drop_cnt), 32'((i + 1) / 2));
`endif
            check_model("alt");
        end

        // Saturation, then clear colliding with a dropped trigger
        bus.len = 4'd15; bus.gap = 4'd15;
        for (int i = 0; i < 330; i++) tick();
        chk("sat.drop", 32'(bus.drop_cnt), 32'(exp_drop()));
`ifdef X_STRETCH_DROP_CNT_EN
        chk("sat.255", 32'(bus.drop_cnt), 32'd255);
`else
        chk("sat.off", 32'(bus.drop_cnt), 32'd0);
`endif
        bus.drop_clr = 1'b1;
        tick();
        bus.drop_clr = 1'b0;
        chk("satclr.drop", 32'(bus.drop_cnt), 32'd0);
        tick();
        check_model("postclr");
        bus.d = 1'b0;
        for (int i = 0; i < 35; i++) tick();
        check_model("idle");

        // Asynchronous reset in the middle of a long pulse
        bus.len = 4'd15; bus.gap = 4'd0; bus.d = 1'b1;
        tick();
        bus.d = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("pre_rst.q", 32'(bus.q), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async.q", 32'(bus.q), 32'd0);
        chk("async.busy", 32'(bus.busy), 32'd0);
        chk("async.drop", 32'(bus.drop_cnt), 32'd0);
        m_hi = 0; m_lo = 0; m_drop = 0;
        tick();
        #2 reset = 1'b0;
        @(posedge clock);
        #1;
        bus.d = 1'b1;
        tick();
        bus.d = 1'b0;
        chk("full.q0", 32'(bus.q), 32'd1);
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk($sformatf("full.q%0d", i), 32'(bus.q), 32'(i < 15));
            check_model("full");
        end

        // Randomized run against the model
        for (int i = 0; i < 600; i++) begin
            if (m_hi == 0 && m_lo == 0 && $urandom_range(0, 3) == 0) begin
                bus.len = 4'($urandom_range(0, 15));
                bus.gap = 4'($urandom_range(0, 5));
            end
            bus.d        = ($urandom_range(0, 2) == 0);
            bus.retrig   = 1'($urandom_range(0, 1));
            bus.drop_clr = ($urandom_range(0, 40) == 0);
            tick();
            check_model($sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
